// File: rtl/heq_pkg.sv
// Shared encodings for the histogram-equalization phase controller: FSM states,
// scratch-memory owner codes and the default frame-counter width.
package heq_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StHist = 3'd1,
    StCdf  = 3'd2,
    StDiv  = 3'd3,
    StMap  = 3'd4,
    StDone = 3'd5
  } heq_state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnHist = 2'd1,
    OwnCdf  = 2'd2,
    OwnDm   = 2'd3
  } heq_owner_e;

  localparam int unsigned DefaultCntW = 32;

  // Divider and mapping share one owner code; they never run concurrently.
  function automatic heq_owner_e owner_of(heq_state_e st);
    case (st)
      StHist:       return OwnHist;
      StCdf:        return OwnCdf;
      StDiv, StMap: return OwnDm;
      default:      return OwnNone;
    endcase
  endfunction

endpackage

// File: rtl/heq_phase_ctrl_if.sv
// Handshake bundle between the phase controller (master) and the pipeline units (slave).
// wd_timeout exists only when HEQ_PHASE_WATCHDOG_EN is defined.
interface heq_phase_ctrl_if
  import heq_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
);
  logic             start;
  logic             abort;
  logic             hist_done;
  logic             cdf_min_valid;
  logic [31:0]      cdf_min_in;
  logic             cdf_done;
  logic             div_sc_mem_wt_done;
  logic             output_wt_done;
  logic             hist_enable;
  logic             cdf_enable;
  logic             div_enable;
  logic             map_enable;
  logic [31:0]      cdf_min;
  logic [1:0]       sc_owner;
  logic [2:0]       phase;
  logic             busy;
  logic             frame_done;
  logic             protocol_err;
  logic [CNT_W-1:0] frame_cycles;
`ifdef HEQ_PHASE_WATCHDOG_EN
  logic             wd_timeout;
`endif

  modport master (
    input  start, abort, hist_done, cdf_min_valid, cdf_min_in, cdf_done,
           div_sc_mem_wt_done, output_wt_done,
`ifdef HEQ_PHASE_WATCHDOG_EN
    output wd_timeout,
`endif
    output hist_enable, cdf_enable, div_enable, map_enable, cdf_min, sc_owner, phase,
           busy, frame_done, protocol_err, frame_cycles
  );

  modport slave (
    output start, abort, hist_done, cdf_min_valid, cdf_min_in, cdf_done,
           div_sc_mem_wt_done, output_wt_done,
`ifdef HEQ_PHASE_WATCHDOG_EN
    input  wd_timeout,
`endif
    input  hist_enable, cdf_enable, div_enable, map_enable, cdf_min, sc_owner, phase,
           busy, frame_done, protocol_err, frame_cycles
  );

endinterface

// File: rtl/heq_watchdog.sv
// Per-phase timeout counter used by heq_phase_ctrl when HEQ_PHASE_WATCHDOG_EN is defined.
// timeout is combinational so the controller can leave the phase on the same edge.
module heq_watchdog #(
  parameter int unsigned WD_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic timeout
);

  localparam int unsigned WdW = $clog2(WD_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(WD_CYCLES - 1);

  logic [WdW-1:0] cnt_q, cnt_d;

  // timeout must not depend on clear: clear is derived from the FSM next state.
  assign timeout = run && (cnt_q == WdLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != WdLast)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/heq_phase_ctrl.sv
// Frame sequencer for histogram equalization: HIST -> CDF -> DIV -> MAP -> DONE.
// Optional per-phase watchdog enabled by defining HEQ_PHASE_WATCHDOG_EN.
module heq_phase_ctrl
  import heq_pkg::*;
#(
  parameter int unsigned CNT_W     = DefaultCntW,
  parameter int unsigned WD_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             reset,
  heq_phase_ctrl_if.master bus
);

  if (WD_CYCLES < 1) begin : g_bad_wd_cycles
    $error("WD_CYCLES must be at least 1");
  end

  heq_state_e       state_q, state_d;
  logic [31:0]      cdf_min_q, cdf_min_d;
  logic             cdf_seen_q, cdf_seen_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] frame_cycles_q, frame_cycles_d;
  logic             hist_en_q, cdf_en_q, div_en_q, map_en_q;
  logic             busy_q, frame_done_q;
  heq_owner_e       sc_owner_q;
  logic             in_frame, stray, missing_min, wd_hit;

`ifdef HEQ_PHASE_WATCHDOG_EN
  logic wd_timeout_q;

  heq_watchdog #(
    .WD_CYCLES(WD_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_d != state_q),
    .run    (in_frame),
    .timeout(wd_hit)
  );

  assign bus.wd_timeout = wd_timeout_q;
`else
  assign wd_hit = 1'b0;
`endif

  assign in_frame = (state_q == StHist) || (state_q == StCdf) ||
                    (state_q == StDiv)  || (state_q == StMap);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // A done pulse that does not belong to the current phase is a protocol violation.
  assign stray = (bus.hist_done          && (state_q != StHist)) ||
                 (bus.cdf_done           && (state_q != StCdf))  ||
                 (bus.div_sc_mem_wt_done && (state_q != StDiv))  ||
                 (bus.output_wt_done     && (state_q != StMap));

  always_comb begin
    state_d        = state_q;
    cdf_min_d      = cdf_min_q;
    cdf_seen_d     = cdf_seen_q;
    err_d          = err_q;
    cnt_d          = cnt_q;
    frame_cycles_d = frame_cycles_q;
    missing_min    = 1'b0;

    if (in_frame) begin
      cnt_d = cnt_inc;
    end

    if ((state_q != StIdle) && (bus.abort || wd_hit)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.abort) begin
            state_d    = StHist;
            cnt_d      = '0;
            err_d      = 1'b0;
            cdf_seen_d = 1'b0;
          end
        end
        StHist: begin
          if (bus.hist_done) state_d = StCdf;
        end
        StCdf: begin
          if (bus.cdf_min_valid) begin
            cdf_min_d  = bus.cdf_min_in;
            cdf_seen_d = 1'b1;
          end
          if (bus.cdf_done) begin
            state_d = StDiv;
            if (!bus.cdf_min_valid && !cdf_seen_q) begin
              cdf_min_d   = '0;
              missing_min = 1'b1;
            end
          end
        end
        StDiv: begin
          if (bus.div_sc_mem_wt_done) state_d = StMap;
        end
        StMap: begin
          if (bus.output_wt_done) begin
            state_d        = StDone;
            frame_cycles_d = cnt_inc;
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    if (stray || missing_min || wd_hit) begin
      err_d = 1'b1;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cdf_min_q      <= '0;
      cdf_seen_q     <= 1'b0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
      frame_cycles_q <= '0;
      hist_en_q      <= 1'b0;
      cdf_en_q       <= 1'b0;
      div_en_q       <= 1'b0;
      map_en_q       <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      sc_owner_q     <= OwnNone;
`ifdef HEQ_PHASE_WATCHDOG_EN
      wd_timeout_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cdf_min_q      <= cdf_min_d;
      cdf_seen_q     <= cdf_seen_d;
      err_q          <= err_d;
      cnt_q          <= cnt_d;
      frame_cycles_q <= frame_cycles_d;
      hist_en_q      <= (state_d == StHist);
      cdf_en_q       <= (state_d == StCdf);
      div_en_q       <= (state_d == StDiv);
      map_en_q       <= (state_d == StMap);
      busy_q         <= (state_d != StIdle);
      frame_done_q   <= (state_d == StDone);
      sc_owner_q     <= owner_of(state_d);
`ifdef HEQ_PHASE_WATCHDOG_EN
      wd_timeout_q   <= wd_hit;
`endif
    end
  end

  assign bus.hist_enable  = hist_en_q;
  assign bus.cdf_enable   = cdf_en_q;
  assign bus.div_enable   = div_en_q;
  assign bus.map_enable   = map_en_q;
  assign bus.cdf_min      = cdf_min_q;
  assign bus.sc_owner     = sc_owner_q;
  assign bus.phase        = state_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.protocol_err = err_q;
  assign bus.frame_cycles = frame_cycles_q;

endmodule

// File: tb/tb_heq_phase_ctrl.sv
// Directed bench for heq_phase_ctrl: nominal frame, stray done, missing cdf_min, abort,
// reset mid-frame and (when HEQ_PHASE_WATCHDOG_EN is defined) the phase watchdog.
module tb_heq_phase_ctrl;

`ifdef HEQ_PHASE_WATCHDOG_EN
  localparam int unsigned WdCycles = 8;
  localparam int unsigned Gap      = 5;
`else
  localparam int unsigned WdCycles = 65535;
  localparam int unsigned Gap      = 10;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  heq_phase_ctrl_if #(.CNT_W(32)) bus ();

  heq_phase_ctrl #(
    .CNT_W    (32),
    .WD_CYCLES(WdCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.abort = 0; bus.hist_done = 0; bus.cdf_min_valid = 0;
    bus.cdf_min_in = '0; bus.cdf_done = 0; bus.div_sc_mem_wt_done = 0; bus.output_wt_done = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;

    // Reset state
    check_eq("rst_phase", bus.phase, 0);
    check_eq("rst_enables", {bus.hist_enable, bus.cdf_enable, bus.div_enable, bus.map_enable}, 0);
    check_eq("rst_owner", bus.sc_owner, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_cdf_min", bus.cdf_min, 0);
    check_eq("rst_frame_cycles", bus.frame_cycles, 0);
    check_eq("rst_err", {bus.protocol_err, bus.frame_done}, 0);

    // Nominal frame, phases Gap cycles apart
    bus.start = 1; step(); bus.start = 0;
    check_eq("nom_hist", {bus.phase, bus.hist_enable, bus.sc_owner, bus.busy}, {3'd1, 1'b1, 2'd1, 1'b1});
    repeat (Gap - 1) step();
    check_eq("nom_hist_hold", {bus.phase, bus.cdf_enable}, {3'd1, 1'b0});
    bus.hist_done = 1; step(); bus.hist_done = 0;
    check_eq("nom_cdf", {bus.phase, bus.hist_enable, bus.cdf_enable, bus.sc_owner},
             {3'd2, 1'b0, 1'b1, 2'd2});
    repeat (Gap / 2 - 1) step();
    bus.cdf_min_valid = 1; bus.cdf_min_in = 32'h11; step();
    bus.cdf_min_valid = 0; bus.cdf_min_in = '0;
    check_eq("nom_cdf_early", bus.cdf_min, 32'h11);
    repeat (Gap - Gap / 2 - 1) step();
    bus.cdf_min_valid = 1; bus.cdf_min_in = 32'h40; bus.cdf_done = 1; step();
    bus.cdf_min_valid = 0; bus.cdf_min_in = '0; bus.cdf_done = 0;
    check_eq("nom_div", {bus.phase, bus.cdf_enable, bus.div_enable, bus.sc_owner},
             {3'd3, 1'b0, 1'b1, 2'd3});
    check_eq("nom_cdf_min", bus.cdf_min, 32'h40);
    repeat (Gap - 1) step();
    bus.div_sc_mem_wt_done = 1; step(); bus.div_sc_mem_wt_done = 0;
    check_eq("nom_map", {bus.phase, bus.div_enable, bus.map_enable, bus.sc_owner},
             {3'd4, 1'b0, 1'b1, 2'd3});
    repeat (Gap - 1) step();
    bus.output_wt_done = 1; step(); bus.output_wt_done = 0;
    check_eq("nom_done", {bus.phase, bus.map_enable, bus.frame_done, bus.busy, bus.sc_owner},
             {3'd5, 1'b0, 1'b1, 1'b1, 2'd0});
    check_eq("nom_frame_cycles", bus.frame_cycles, 4 * Gap);
    step();
    check_eq("nom_idle", {bus.phase, bus.frame_done, bus.busy, bus.protocol_err}, 0);

    // Stray div done during HIST
    bus.start = 1; step(); bus.start = 0;
    bus.div_sc_mem_wt_done = 1; step(); bus.div_sc_mem_wt_done = 0;
    check_eq("stray_hold", {bus.phase, bus.hist_enable, bus.div_enable}, {3'd1, 1'b1, 1'b0});
    check_eq("stray_err", bus.protocol_err, 1);
    bus.abort = 1; step(); bus.abort = 0;
    check_eq("stray_abort_idle", {bus.phase, bus.hist_enable, bus.protocol_err}, {3'd0, 1'b0, 1'b1});
    bus.start = 1; step(); bus.start = 0;
    check_eq("stray_start_clears", {bus.phase, bus.protocol_err}, {3'd1, 1'b0});

    // Start while busy is ignored without error
    bus.start = 1; step(); bus.start = 0;
    check_eq("busy_start", {bus.phase, bus.protocol_err}, {3'd1, 1'b0});

    // Missing cdf_min
    bus.hist_done = 1; step(); bus.hist_done = 0;
    bus.cdf_done = 1; step(); bus.cdf_done = 0;
    check_eq("miss_div", {bus.phase, bus.div_enable}, {3'd3, 1'b1});
    check_eq("miss_cdf_min", bus.cdf_min, 0);
    check_eq("miss_err", bus.protocol_err, 1);

    // Abort in MAP coincident with output_wt_done
    bus.div_sc_mem_wt_done = 1; step(); bus.div_sc_mem_wt_done = 0;
    check_eq("abort_in_map", bus.phase, 4);
    bus.abort = 1; bus.output_wt_done = 1; step(); bus.abort = 0; bus.output_wt_done = 0;
    check_eq("abort_idle", {bus.phase, bus.map_enable, bus.frame_done, bus.busy}, 0);
    check_eq("abort_frame_cycles", bus.frame_cycles, 4 * Gap);
    step();
    check_eq("abort_no_done", bus.frame_done, 0);

    // Reset during DIV, overriding a simultaneous abort
    bus.start = 1; step(); bus.start = 0;
    bus.hist_done = 1; step(); bus.hist_done = 0;
    bus.cdf_min_valid = 1; bus.cdf_min_in = 32'h77; bus.cdf_done = 1; step();
    bus.cdf_min_valid = 0; bus.cdf_min_in = '0; bus.cdf_done = 0;
    check_eq("rmid_div", {bus.phase, bus.cdf_min}, {3'd3, 32'h77});
    reset = 1; bus.abort = 1; step(); reset = 0; bus.abort = 0;
    check_eq("rmid_outputs", {bus.phase, bus.div_enable, bus.sc_owner, bus.busy,
                              bus.protocol_err, bus.frame_done}, 0);
    check_eq("rmid_regs", {bus.cdf_min, bus.frame_cycles}, 0);
    bus.start = 1; step(); bus.start = 0;
    check_eq("rmid_restart", {bus.phase, bus.hist_enable}, {3'd1, 1'b1});

    // Short frame: valid outside CDF ignored, valid then later done without valid
    bus.hist_done = 1; bus.cdf_min_valid = 1; bus.cdf_min_in = 32'h999; step();
    bus.hist_done = 0; bus.cdf_min_valid = 0; bus.cdf_min_in = '0;
    check_eq("short_ignore_valid", bus.cdf_min, 0);
    bus.cdf_min_valid = 1; bus.cdf_min_in = 32'h123; step();
    bus.cdf_min_valid = 0; bus.cdf_min_in = '0;
    bus.cdf_done = 1; step(); bus.cdf_done = 0;
    bus.div_sc_mem_wt_done = 1; step(); bus.div_sc_mem_wt_done = 0;
    bus.output_wt_done = 1; step(); bus.output_wt_done = 0;
    check_eq("short_done", {bus.phase, bus.frame_done}, {3'd5, 1'b1});
    check_eq("short_cycles", bus.frame_cycles, 5);
    check_eq("short_cdf_min", {bus.cdf_min, bus.protocol_err}, {32'h123, 1'b0});
    step();

    // Stray done in IDLE
    bus.hist_done = 1; step(); bus.hist_done = 0;
    check_eq("idle_stray", {bus.phase, bus.protocol_err}, {3'd0, 1'b1});

`ifdef HEQ_PHASE_WATCHDOG_EN
    bus.start = 1; step(); bus.start = 0;
    check_eq("wd_hist", {bus.phase, bus.wd_timeout}, {3'd1, 1'b0});
    repeat (WdCycles - 1) begin
      step();
      check_eq("wd_wait", {bus.phase, bus.wd_timeout}, {3'd1, 1'b0});
    end
    step();
    check_eq("wd_fire", {bus.phase, bus.wd_timeout, bus.protocol_err, bus.hist_enable},
             {3'd0, 1'b1, 1'b1, 1'b0});
    step();
    check_eq("wd_pulse_end", bus.wd_timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
